// File: rtl/apb2axi_txn_sched_if.sv
// Bus bundle for the transaction scheduler: gateway input, WR/RD request
// outputs, completion pulses and status.
//
// Handshake semantics (pending_*, wr_push_*, rd_push_*): a transfer happens on
// a rising aclk edge where valid && ready (pending_pop plays the ready role on
// the gateway side). Once valid is raised, valid and data stay stable until the
// transfer happens. Ready may depend combinationally on valid. Valid never
// depends on ready.
interface apb2axi_txn_sched_if #(
  parameter int ENTRY_W = 32,
  parameter int DEPTH   = 4,
  parameter int STALL_W = 16
);
  // Gateway side
  logic                     pending_valid;
  logic [ENTRY_W-1:0]       pending_entry;
  logic                     pending_pop;
  // Write request FIFO side
  logic                     wr_push_valid;
  logic                     wr_push_ready;
  logic [ENTRY_W-1:0]       wr_push_data;
  // Read request FIFO side
  logic                     rd_push_valid;
  logic                     rd_push_ready;
  logic [ENTRY_W-1:0]       rd_push_data;
  // Completion pulses
  logic                     wr_done;
  logic                     rd_done;
  // Status
  logic [$clog2(DEPTH):0]   q_count;
  logic [7:0]               wr_credits;
  logic [7:0]               rd_credits;
  logic [STALL_W-1:0]       stall_cnt;
  logic                     credit_err;

  // Scheduler side
  modport slave (
    input  pending_valid, pending_entry, wr_push_ready, rd_push_ready,
           wr_done, rd_done,
    output pending_pop, wr_push_valid, wr_push_data, rd_push_valid,
           rd_push_data, q_count, wr_credits, rd_credits, stall_cnt,
           credit_err
  );

  // Environment side (gateway, FIFOs, completion logic)
  modport master (
    output pending_valid, pending_entry, wr_push_ready, rd_push_ready,
           wr_done, rd_done,
    input  pending_pop, wr_push_valid, wr_push_data, rd_push_valid,
           rd_push_data, q_count, wr_credits, rd_credits, stall_cnt,
           credit_err
  );
endinterface

// File: rtl/apb2axi_txn_sched.sv
// Credit-aware in-order transaction scheduler (AXI clock domain).
// Committed gateway entries go into a small circular queue. The head entry is
// dispatched into a per-direction registered output stage when that stage is
// free and the direction has outstanding-transaction credit. The MSB of an
// entry is its is_write flag. Dispatch is strictly in order: a blocked head
// blocks everything behind it, whatever the direction.
module apb2axi_txn_sched #(
  parameter int ENTRY_W    = 32,  // packed directory entry width
  parameter int DEPTH      = 4,   // power of 2, >= 2
  parameter int WR_CREDITS = 4,   // 1..255
  parameter int RD_CREDITS = 4,   // 1..255
  parameter int STALL_W    = 16
) (
  input  logic aclk,
  input  logic areset,
  apb2axi_txn_sched_if.slave bus
);

  localparam int            AW     = $clog2(DEPTH);
  localparam int            CW     = AW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [7:0]    WR_MAX = 8'(WR_CREDITS);
  localparam logic [7:0]    RD_MAX = 8'(RD_CREDITS);

  logic [ENTRY_W-1:0] r_q [DEPTH];
  logic [AW-1:0]      r_head;
  logic [AW-1:0]      r_tail;
  logic [CW-1:0]      r_count;
  logic               r_wr_valid;
  logic [ENTRY_W-1:0] r_wr_data;
  logic               r_rd_valid;
  logic [ENTRY_W-1:0] r_rd_data;
  logic [7:0]         r_wr_cred;
  logic [7:0]         r_rd_cred;
  logic [STALL_W-1:0] r_stall;
  logic               r_credit_err;

  logic               w_accept;
  logic               w_not_empty;
  logic [ENTRY_W-1:0] w_head_entry;
  logic               w_head_is_wr;
  logic               w_wr_free;
  logic               w_rd_free;
  logic               w_disp_wr;
  logic               w_disp_rd;
  logic               w_disp;

  // Acceptance looks only at the registered count, so a full queue never
  // accepts even when the head leaves on the same edge.
  assign w_accept     = bus.pending_valid && (r_count < FULL);
  assign w_not_empty  = (r_count != '0);
  assign w_head_entry = r_q[r_head];
  assign w_head_is_wr = w_head_entry[ENTRY_W-1];

  // An output register can take a new entry if empty or draining this cycle.
  assign w_wr_free = !r_wr_valid || bus.wr_push_ready;
  assign w_rd_free = !r_rd_valid || bus.rd_push_ready;

  assign w_disp_wr = w_not_empty &&  w_head_is_wr && w_wr_free && (r_wr_cred != 8'd0);
  assign w_disp_rd = w_not_empty && !w_head_is_wr && w_rd_free && (r_rd_cred != 8'd0);
  assign w_disp    = w_disp_wr || w_disp_rd;

  // Queue storage: written at the tail on accept; contents need no reset.
  always_ff @(posedge aclk) begin
    if (w_accept) r_q[r_tail] <= bus.pending_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) r_tail <= r_tail + AW'(1);
      if (w_disp)   r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_accept) - CW'(w_disp);
    end
  end

  // Write output stage: load on dispatch, hold while stalled, drop on transfer.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_valid <= 1'b0;
      r_wr_data  <= '0;
    end else if (w_disp_wr) begin
      r_wr_valid <= 1'b1;
      r_wr_data  <= w_head_entry;
    end else if (r_wr_valid && bus.wr_push_ready) begin
      r_wr_valid <= 1'b0;
    end
  end

  // Read output stage: same behaviour as the write stage.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (w_disp_rd) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= w_head_entry;
    end else if (r_rd_valid && bus.rd_push_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

  // Credits: next = cur - dispatch + done. A done at max without a same-cycle
  // dispatch is dropped and flagged in the sticky error bit.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_cred    <= WR_MAX;
      r_rd_cred    <= RD_MAX;
      r_credit_err <= 1'b0;
    end else begin
      if (w_disp_wr && !bus.wr_done) begin
        r_wr_cred <= r_wr_cred - 8'd1;
      end else if (!w_disp_wr && bus.wr_done) begin
        if (r_wr_cred == WR_MAX) r_credit_err <= 1'b1;
        else                     r_wr_cred    <= r_wr_cred + 8'd1;
      end
      if (w_disp_rd && !bus.rd_done) begin
        r_rd_cred <= r_rd_cred - 8'd1;
      end else if (!w_disp_rd && bus.rd_done) begin
        if (r_rd_cred == RD_MAX) r_credit_err <= 1'b1;
        else                     r_rd_cred    <= r_rd_cred + 8'd1;
      end
    end
  end

  // Head-of-line stall counter: clears on dispatch, saturates, holds when empty.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_stall <= '0;
    end else if (w_disp) begin
      r_stall <= '0;
    end else if (w_not_empty && (r_stall != {STALL_W{1'b1}})) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

  assign bus.pending_pop   = w_accept;
  assign bus.wr_push_valid = r_wr_valid;
  assign bus.wr_push_data  = r_wr_data;
  assign bus.rd_push_valid = r_rd_valid;
  assign bus.rd_push_data  = r_rd_data;
  assign bus.q_count       = r_count;
  assign bus.wr_credits    = r_wr_cred;
  assign bus.rd_credits    = r_rd_cred;
  assign bus.stall_cnt     = r_stall;
  assign bus.credit_err    = r_credit_err;

endmodule

// File: tb/tb_apb2axi_txn_sched.sv
// Directed bench for apb2axi_txn_sched. Entries are 16 bits wide with bit 15
// as is_write. Every offered entry is pushed onto exp_q. A monitor pops and
// compares on each output-stage transfer, so order across WR/RD is checked
// against issue order.
module tb_apb2axi_txn_sched;
  localparam int EW    = 16;
  localparam int DEPTH = 4;
  localparam int SW    = 16;

  logic aclk;
  logic areset;
  int   errors = 0;
  int   checks = 0;
  logic [EW-1:0] exp_q[$];

  apb2axi_txn_sched_if #(.ENTRY_W(EW), .DEPTH(DEPTH), .STALL_W(SW)) bus ();

  apb2axi_txn_sched #(
    .ENTRY_W(EW), .DEPTH(DEPTH), .WR_CREDITS(4), .RD_CREDITS(4), .STALL_W(SW)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // Offer one entry and hold it until accepted (bounded). Returns the number
  // of cycles spent waiting on pending_pop.
  task automatic offer(input logic [EW-1:0] e, output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    exp_q.push_back(e);
    bus.pending_valid = 1'b1;
    bus.pending_entry = e;
    for (int i = 0; i < 32 && !got; i++) begin
      @(negedge aclk);
      if (bus.pending_pop) got = 1'b1;
      else                 waited++;
      @(posedge aclk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout: entry %0h not accepted", e);
    end
    bus.pending_valid = 1'b0;
  endtask

  // nw cycles of wr_done and nr cycles of rd_done, starting together.
  task automatic pulses(input int nw, input int nr);
    int n;
    n = (nw > nr) ? nw : nr;
    for (int i = 0; i < n; i++) begin
      bus.wr_done = (i < nw);
      bus.rd_done = (i < nr);
      cyc();
    end
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic check_out(input string name, input logic [EW-1:0] act);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected output %0h, nothing expected", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'(act), 32'(e));
    end
  endtask

  initial begin
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (bus.wr_push_valid && bus.wr_push_ready) check_out("wr_out", bus.wr_push_data);
        if (bus.rd_push_valid && bus.rd_push_ready) check_out("rd_out", bus.rd_push_data);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int w;
    areset            = 1'b1;
    bus.pending_valid = 1'b0;
    bus.pending_entry = '0;
    bus.wr_push_ready = 1'b1;
    bus.rd_push_ready = 1'b1;
    bus.wr_done       = 1'b0;
    bus.rd_done       = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk("rst_q_count",   32'(bus.q_count), 0);
    chk("rst_wr_valid",  32'(bus.wr_push_valid), 0);
    chk("rst_rd_valid",  32'(bus.rd_push_valid), 0);
    chk("rst_wr_data",   32'(bus.wr_push_data), 0);
    chk("rst_wr_cred",   32'(bus.wr_credits), 4);
    chk("rst_rd_cred",   32'(bus.rd_credits), 4);
    chk("rst_stall",     32'(bus.stall_cnt), 0);
    chk("rst_err",       32'(bus.credit_err), 0);
    areset = 1'b0;
    cyc();

    // T1: three back-to-back writes
    offer(16'h8001, w); chk("t1_pop0", 32'(w), 0);
    offer(16'h8002, w); chk("t1_pop1", 32'(w), 0);
    offer(16'h8003, w); chk("t1_pop2", 32'(w), 0);
    chk("t1_q_count", 32'(bus.q_count), 1);
    chk("t1_wr_valid", 32'(bus.wr_push_valid), 1);
    cyc();
    chk("t1_q_empty", 32'(bus.q_count), 0);
    chk("t1_wr_cred", 32'(bus.wr_credits), 1);
    pulses(3, 0);
    chk("t1_cred_back", 32'(bus.wr_credits), 4);

    // T2: five writes, four credits
    for (int i = 0; i < 5; i++) offer(16'h8010 + 16'(i), w);
    repeat (3) cyc();
    chk("t2_wr_cred0", 32'(bus.wr_credits), 0);
    chk("t2_q_count",  32'(bus.q_count), 1);
    chk("t2_stall3",   32'(bus.stall_cnt), 3);
    pulses(1, 0);
    chk("t2_cred1",    32'(bus.wr_credits), 1);
    chk("t2_stall4",   32'(bus.stall_cnt), 4);
    cyc();
    chk("t2_stall_clr", 32'(bus.stall_cnt), 0);
    chk("t2_q_empty",   32'(bus.q_count), 0);
    chk("t2_cred_used", 32'(bus.wr_credits), 0);
    pulses(4, 0);
    chk("t2_cred_back", 32'(bus.wr_credits), 4);
    chk("t2_no_err",    32'(bus.credit_err), 0);

    // T3: back-pressure on the write FIFO
    bus.wr_push_ready = 1'b0;
    for (int i = 0; i < 5; i++) offer(16'h8020 + 16'(i), w);
    bus.pending_valid = 1'b1;
    bus.pending_entry = 16'h8025;
    #1;
    chk("t3_pop_full", 32'(bus.pending_pop), 0);
    chk("t3_q_full",   32'(bus.q_count), 4);
    for (int i = 0; i < 3; i++) begin
      chk("t3_valid_held", 32'(bus.wr_push_valid), 1);
      chk("t3_data_held",  32'(bus.wr_push_data), 32'h8020);
      cyc();
    end
    bus.wr_push_ready = 1'b1;
    offer(16'h8025, w);
    chk("t3_wait_one", 32'(w), 1);
    pulses(6, 0);
    chk("t3_cred_back", 32'(bus.wr_credits), 4);
    chk("t3_q_empty",   32'(bus.q_count), 0);

    // T4: W,R,W behind exhausted write credits
    for (int i = 0; i < 4; i++) offer(16'h8030 + 16'(i), w);
    offer(16'h8040, w);
    offer(16'h0041, w);
    offer(16'h8042, w);
    for (int i = 0; i < 3; i++) begin
      chk("t4_rd_blocked", 32'(bus.rd_push_valid), 0);
      chk("t4_q_count",    32'(bus.q_count), 3);
      cyc();
    end
    chk("t4_rd_cred_untouched", 32'(bus.rd_credits), 4);
    pulses(1, 0);
    repeat (2) cyc();
    chk("t4_rd_cred_used", 32'(bus.rd_credits), 3);
    pulses(5, 1);
    chk("t4_wr_cred_back", 32'(bus.wr_credits), 4);
    chk("t4_rd_cred_back", 32'(bus.rd_credits), 4);
    chk("t4_no_err",       32'(bus.credit_err), 0);

    // T5: done at max, then dispatch with same-cycle done
    pulses(1, 0);
    chk("t5_cred_max", 32'(bus.wr_credits), 4);
    chk("t5_err_set",  32'(bus.credit_err), 1);
    offer(16'h8050, w);
    offer(16'h8051, w);
    cyc();
    chk("t5_cred2", 32'(bus.wr_credits), 2);
    offer(16'h8052, w);
    pulses(1, 0);
    chk("t5_cred_same", 32'(bus.wr_credits), 2);
    chk("t5_wr_valid",  32'(bus.wr_push_valid), 1);
    pulses(2, 0);
    chk("t5_cred_back", 32'(bus.wr_credits), 4);
    chk("t5_err_sticky", 32'(bus.credit_err), 1);

    // T6: reset with 3 queued and 1 staged
    bus.wr_push_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(16'h8060 + 16'(i), w);
    chk("t6_q_before", 32'(bus.q_count), 3);
    areset = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_q_count",  32'(bus.q_count), 0);
    chk("t6_wr_valid", 32'(bus.wr_push_valid), 0);
    chk("t6_wr_data",  32'(bus.wr_push_data), 0);
    chk("t6_wr_cred",  32'(bus.wr_credits), 4);
    chk("t6_stall",    32'(bus.stall_cnt), 0);
    chk("t6_err_clr",  32'(bus.credit_err), 0);
    cyc();
    areset = 1'b0;
    bus.wr_push_ready = 1'b1;
    cyc();
    offer(16'h0070, w);
    chk("t6_rd_not_yet", 32'(bus.rd_push_valid), 0);
    cyc();
    chk("t6_rd_valid", 32'(bus.rd_push_valid), 1);
    chk("t6_rd_data",  32'(bus.rd_push_data), 32'h0070);
    chk("t6_rd_cred",  32'(bus.rd_credits), 3);
    pulses(0, 1);
    repeat (2) cyc();
    chk("t6_rd_cred_back", 32'(bus.rd_credits), 4);
    chk("exp_q_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
